system_bridge: RTL and testbench

Parametrised memory-mapped bridge between the CPU data port and `NUM_DEV` peripherals (data memory, timers, future I/O). It decodes the CPU address against per-device windows and runs a registered request/acknowledge handshake with the selected device, so multi-cycle devices are supported. It raises a fault on unmapped addresses, illegal partial writes and device timeouts. It sits between the MEM stage and the device bank, replacing the fixed three-way combinational decoder.

---
 rtl/bridge_pkg.sv | 16 +
 rtl/system_bridge_if.sv | 30 +++
 rtl/bridge_decoder.sv | 27 ++
 rtl/system_bridge.sv | 130 +++++++++++++
 tb/tb_system_bridge.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-device bridge.
package bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/system_bridge_if.sv
// CPU data-port and device-bank signals of the bridge, grouped as one bus.
interface system_bridge_if #(
    parameter int unsigned NUM_DEV = 4
);
    logic                    cpu_req;
    logic [31:0]             cpu_addr;
    logic [3:0]              cpu_byteen;
    logic [31:0]             cpu_wdata;
    logic                    cpu_ready;
    logic [31:0]             cpu_rdata;
    logic                    cpu_fault;
    logic [NUM_DEV-1:0]      dev_sel;
    logic [31:0]             dev_addr;
    logic [3:0]              dev_byteen;
    logic [31:0]             dev_wdata;
    logic [NUM_DEV-1:0]      dev_ack;
    logic [NUM_DEV*32-1:0]   dev_rdata;

    // Environment side: CPU plus device bank.
    modport master (
        output cpu_req, cpu_addr, cpu_byteen, cpu_wdata, dev_ack, dev_rdata,
        input  cpu_ready, cpu_rdata, cpu_fault, dev_sel, dev_addr, dev_byteen, dev_wdata
    );

    // Bridge side.
    modport slave (
        input  cpu_req, cpu_addr, cpu_byteen, cpu_wdata, dev_ack, dev_rdata,
        output cpu_ready, cpu_rdata, cpu_fault, dev_sel, dev_addr, dev_byteen, dev_wdata
    );
endinterface

// File: rtl/bridge_decoder.sv
// Combinational address decoder: lowest-index window containing addr wins.
module bridge_decoder
    import bridge_pkg::*;
#(
    parameter int unsigned                NUM_DEV    = 4,
    parameter logic [NUM_DEV*ADDR_W-1:0]  ADDR_BASE  = '0,
    parameter logic [NUM_DEV*ADDR_W-1:0]  ADDR_LIMIT = '0
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_DEV-1:0] hit,
    output logic               miss
);

    always_comb begin
        hit  = '0;
        miss = 1'b1;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (miss &&
                addr >= ADDR_BASE[ADDR_W*i +: ADDR_W] &&
                addr <= ADDR_LIMIT[ADDR_W*i +: ADDR_W]) begin
                hit[i] = 1'b1;
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/system_bridge.sv
// Memory-mapped bridge: decodes CPU accesses to NUM_DEV devices and runs a
// registered req/ack handshake with timeout and fault reporting.
module system_bridge
    import bridge_pkg::*;
#(
    parameter int unsigned                NUM_DEV    = 4,
    parameter logic [NUM_DEV*ADDR_W-1:0]  ADDR_BASE  = {32'h0000_3000, 32'h0000_2000,
                                                        32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_DEV*ADDR_W-1:0]  ADDR_LIMIT = {32'h0000_3FFF, 32'h0000_2FFF,
                                                        32'h0000_1FFF, 32'h0000_0FFF},
    parameter logic [NUM_DEV-1:0]         WORD_ONLY  = 4'b1110,
    parameter int unsigned                TIMEOUT    = 16
) (
    input  logic           clk,
    input  logic           reset,
    system_bridge_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_DEV-1:0]  sel_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ready_q;
    logic                fault_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [NUM_DEV-1:0]  hit;
    logic                miss;
    logic                bad_write;
    logic                ack_hit;
    logic [DATA_W-1:0]   rdata_mux;

    bridge_decoder #(
        .NUM_DEV    (NUM_DEV),
        .ADDR_BASE  (ADDR_BASE),
        .ADDR_LIMIT (ADDR_LIMIT)
    ) u_decoder (
        .addr (bus.cpu_addr),
        .hit  (hit),
        .miss (miss)
    );

    // Partial writes to word-only devices, ack of the selected device, read mux.
    always_comb begin
        bad_write = (bus.cpu_byteen != '0) && ((hit & WORD_ONLY) != '0) &&
                    (bus.cpu_byteen != BE_WORD);
        ack_hit   = (bus.dev_ack & sel_q) != '0;
        rdata_mux = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_q[i]) begin
                rdata_mux = rdata_mux | bus.dev_rdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (bus.cpu_req) begin
                        if (miss || bad_write) begin
                            fault_q <= 1'b1;
                            rdata_q <= '0;
                            ready_q <= 1'b1;
                            state   <= DONE;
                        end else begin
                            addr_q  <= bus.cpu_addr;
                            be_q    <= bus.cpu_byteen;
                            wdata_q <= bus.cpu_wdata;
                            sel_q   <= hit;
                            cnt     <= '0;
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (ack_hit) begin
                        rdata_q <= rdata_mux;
                        fault_q <= 1'b0;
                        sel_q   <= '0;
                        ready_q <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rdata_q <= '0;
                        fault_q <= 1'b1;
                        sel_q   <= '0;
                        ready_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    sel_q   <= '0;
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.dev_sel    = sel_q;
    assign bus.dev_addr   = addr_q;
    assign bus.dev_byteen = be_q;
    assign bus.dev_wdata  = wdata_q;
    assign bus.cpu_ready  = ready_q;
    assign bus.cpu_fault  = fault_q;
    assign bus.cpu_rdata  = rdata_q;

endmodule

// File: tb/tb_system_bridge.sv
// Scoreboard bench for system_bridge: directed accesses, a simple device
// responder with per-device latency, and a monitor checking every cpu_ready.
module tb_system_bridge;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        bit          check_rdata;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb_q[$];
    int   lat[4];
    logic [3:0] spurious;

    system_bridge_if #(.NUM_DEV(4)) bus();

    system_bridge #(
        .NUM_DEV    (4),
        .ADDR_BASE  ({32'h0000_3000, 32'h0000_2000, 32'h0000_0800, 32'h0000_0000}),
        .ADDR_LIMIT ({32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF}),
        .WORD_ONLY  (4'b1110),
        .TIMEOUT    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Device bank: device i acks once it has been selected for more than lat[i] cycles.
    initial begin
        int   seen;
        logic [3:0] a;
        seen = 0;
        bus.dev_ack   = '0;
        bus.dev_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hDEAD_BEEF};
        forever begin
            @(negedge clk);
            if (bus.dev_sel != '0) seen++;
            else seen = 0;
            a = spurious;
            for (int i = 0; i < 4; i++)
                if (bus.dev_sel[i] && (seen - 1) >= lat[i]) a[i] = 1'b1;
            bus.dev_ack = a;
        end
    end

    // Monitor: every completion must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cpu_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_ready: got response rdata=%h fault=%b, expected none",
                             bus.cpu_rdata, bus.cpu_fault);
                end else begin
                    e = sb_q.pop_front();
                    chk("cpu_fault", 32'(bus.cpu_fault), 32'(e.fault));
                    if (e.check_rdata) chk("cpu_rdata", bus.cpu_rdata, e.rdata);
                end
            end
        end
    end

    // Issue one access and check strobe timing; the response goes to the scoreboard.
    task automatic access(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                          input logic [3:0] exp_sel, input int exp_sel_cycles, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_fault, input bit chk_rd,
                          input bit perturb);
        exp_t e;
        int   sel_cycles;
        int   done_at;
        sel_cycles = 0;
        done_at    = -1;
        @(negedge clk);
        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = addr;
        bus.cpu_byteen = be;
        bus.cpu_wdata  = wd;
        e.rdata = exp_rdata;
        e.fault = exp_fault;
        e.check_rdata = chk_rd;
        sb_q.push_back(e);
        @(posedge clk);
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.cpu_ready === 1'b1) begin
                done_at = n;
                bus.cpu_req = 1'b0;
                break;
            end
            if (bus.dev_sel != '0) begin
                sel_cycles++;
                chk("dev_sel", 32'(bus.dev_sel), 32'(exp_sel));
                chk("dev_addr", bus.dev_addr, addr);
                chk("dev_byteen", 32'(bus.dev_byteen), 32'(be));
                chk("dev_wdata", bus.dev_wdata, wd);
            end
            if (perturb && n == 1) begin
                bus.cpu_addr   = 32'h0000_3004;
                bus.cpu_byteen = 4'b0011;
                bus.cpu_wdata  = 32'h5555_AAAA;
            end
        end
        bus.cpu_req = 1'b0;
        chk("ready_latency", 32'(done_at), 32'(exp_lat));
        chk("dev_sel_cycles", 32'(sel_cycles), 32'(exp_sel_cycles));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) lat[i] = 0;
        spurious       = '0;
        reset          = 1'b1;
        bus.cpu_req    = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_byteen = '0;
        bus.cpu_wdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_cpu_fault", 32'(bus.cpu_fault), 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_dev_sel", 32'(bus.dev_sel), 32'd0);
        chk("rst_dev_addr", bus.dev_addr, 32'd0);
        reset = 1'b0;

        // Zero-wait read from device 0.
        lat[0] = 0;
        access(32'h0000_0010, 4'b0000, 32'h0, 4'b0001, 1, 2, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);

        // Word write to device 1, 3 wait states, spurious ack from device 0, inputs perturbed.
        lat[1] = 3;
        spurious = 4'b0001;
        access(32'h0000_1004, 4'b1111, 32'hCAFE_F00D, 4'b0010, 4, 5, 32'h0, 1'b0, 1'b0, 1'b1);
        spurious = '0;

        // Byte write to word-only device 2 and read of an unmapped address.
        access(32'h0000_2000, 4'b0001, 32'h0000_00AB, 4'b0000, 0, 1, 32'h0, 1'b1, 1'b0, 1'b0);
        access(32'h0000_9000, 4'b0000, 32'h0, 4'b0000, 0, 1, 32'h0, 1'b1, 1'b0, 1'b0);

        // Device 3 never acks: timeout; then ack on the last allowed cycle.
        lat[3] = 1000;
        access(32'h0000_3000, 4'b0000, 32'h0, 4'b1000, 16, 17, 32'h0, 1'b1, 1'b1, 1'b0);
        lat[3] = 15;
        access(32'h0000_3000, 4'b0000, 32'h0, 4'b1000, 16, 17, 32'h3333_0003, 1'b0, 1'b1, 1'b0);

        // Overlap of windows 0 and 1: device 0 wins; byte write to non-word-only device 0.
        access(32'h0000_0900, 4'b0000, 32'h0, 4'b0001, 1, 2, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        access(32'h0000_0004, 4'b0001, 32'h0000_0077, 4'b0001, 1, 2, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset during ACCESS aborts with no response; next access completes.
        lat[3] = 1000;
        @(negedge clk);
        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = 32'h0000_3010;
        bus.cpu_byteen = 4'b0000;
        repeat (3) @(negedge clk);
        chk("pre_reset_dev_sel", 32'(bus.dev_sel), 32'b1000);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        chk("abort_dev_sel", 32'(bus.dev_sel), 32'd0);
        chk("abort_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        reset = 1'b0;
        lat[2] = 1;
        access(32'h0000_2008, 4'b0000, 32'h0, 4'b0100, 2, 3, 32'h2222_0002, 1'b0, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
